// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Round-robin bus arbiter with halt-aware timeout
// Serialises NUM_MASTERS requesters onto one downstream port. Each
// transaction walks IDLE -> ISSUE -> WAIT -> DONE; WAIT stretches while the
// downstream halts and gives up with an error after TIMEOUT_CYCLES.

package cpu_reg_package;
  localparam int ADDRESS_WIDTH = 16;
  localparam int DATA_WIDTH    = 16;
endpackage

module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int address_width  = cpu_reg_package::ADDRESS_WIDTH,
  parameter int data_width     = cpu_reg_package::DATA_WIDTH
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [NUM_MASTERS-1:0]                    req_i,
  input  logic [NUM_MASTERS-1:0]                    m_we_i,
  input  logic [NUM_MASTERS-1:0][address_width-1:0] m_address_i,
  input  logic [NUM_MASTERS-1:0][data_width-1:0]    m_data_i,
  output logic [NUM_MASTERS-1:0]                    gnt_o,
  output logic [NUM_MASTERS-1:0]                    ack_o,
  output logic                                      err_o,
  output logic [data_width-1:0]                     m_data_o,
  output logic                                      we_o,
  output logic [address_width-1:0]                  address_o,
  output logic [data_width-1:0]                     data_o,
  input  logic [data_width-1:0]                     data_i,
  input  logic                                      cpu_halt_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    wdata_q, wdata_d;
  logic [data_width-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         cand;

  // Round-robin winner: first requesting master at or above rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic; we_o and err_o default low so they only pulse.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d         = S_ISSUE;
          owner_d         = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          addr_d          = m_address_i[pick_idx];
          wdata_d         = m_data_i[pick_idx];
          we_d            = m_we_i[pick_idx];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!cpu_halt_i) begin
          state_d = S_DONE;
          rdata_d = data_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // The halt cycle that brings the count to TIMEOUT_CYCLES ends WAIT.
          if (({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES)) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
      end
    endcase
  end

  // State registers; reset aborts any transaction in flight without an ack.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = (state_q == S_DONE) ? gnt_q : '0;
  assign err_o     = err_q;
  assign m_data_o  = rdata_q;
  assign we_o      = we_q;
  assign address_o = addr_q;
  assign data_o    = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - Scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int T  = 8;
  localparam int AW = 16;
  localparam int DW = 16;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic [N-1:0]           req_i = '0;
  logic [N-1:0]           m_we_i = '0;
  logic [N-1:0][AW-1:0]   m_address_i = '0;
  logic [N-1:0][DW-1:0]   m_data_i = '0;
  logic [N-1:0]           gnt_o;
  logic [N-1:0]           ack_o;
  logic                   err_o;
  logic [DW-1:0]          m_data_o;
  logic                   we_o;
  logic [AW-1:0]          address_o;
  logic [DW-1:0]          data_o;
  logic [DW-1:0]          data_i = '0;
  logic                   cpu_halt_i = 1'b0;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .m_we_i(m_we_i),
    .m_address_i(m_address_i), .m_data_i(m_data_i), .gnt_o(gnt_o),
    .ack_o(ack_o), .err_o(err_o), .m_data_o(m_data_o), .we_o(we_o),
    .address_o(address_o), .data_o(data_o), .data_i(data_i),
    .cpu_halt_i(cpu_halt_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int m; int cyc; logic err; logic [DW-1:0] rdata; logic [AW-1:0] addr;} ack_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data;} iss_t;
  ack_t ack_q[$];
  iss_t iss_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: round-robin pointer and outstanding requests.
  int ptr = 0;
  bit pending[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pending[m]     = 1'b1;
    m_we_i[m]      = we;
    m_address_i[m] = a;
    m_data_i[m]    = d;
    req_i[m]       = 1'b1;
  endtask

  task automatic rand_master(input int m);
    set_master(m, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic clear_all();
    req_i      = '0;
    cpu_halt_i = 1'b0;
    ptr        = 0;
    for (int m = 0; m < N; m++) pending[m] = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_all();
    step();
    step();
    reset_i = 1'b0;
  endtask

  // One transaction starting in an IDLE cycle. h = halt cycles requested in WAIT.
  task automatic txn(input int h, input logic [N-1:0] late, input logic [DW-1:0] dval,
                     input bit abort, output int served);
    int   w;
    int   t0;
    int   lat;
    ack_t e;
    iss_t s;
    t0 = cyc;
    w  = -1;
    for (int i = 0; i < N; i++) begin
      if (w < 0 && pending[(ptr + i) % N]) w = (ptr + i) % N;
    end
    served = w;
    if (w < 0) return;
    lat = (h >= T) ? (2 + T) : (3 + h);
    if (m_we_i[w]) begin
      s.cyc = t0 + 1; s.addr = m_address_i[w]; s.data = m_data_i[w];
      iss_q.push_back(s);
    end
    if (!abort) begin
      e.m = w; e.cyc = t0 + lat; e.err = (h >= T);
      e.rdata = (h >= T) ? '0 : dval; e.addr = m_address_i[w];
      ack_q.push_back(e);
    end
    step();
    data_i     = dval;
    cpu_halt_i = (h > 0);
    step();
    for (int m = 0; m < N; m++) if (late[m] && !pending[m]) rand_master(m);
    if (abort) begin
      reset_i = 1'b1;
      clear_all();
      step();
      reset_i = 1'b0;
      return;
    end
    for (int j = 0; j < lat - 2; j++) begin
      cpu_halt_i = (j < h);
      step();
    end
    cpu_halt_i = 1'b0;
    step();
    req_i[w]   = 1'b0;
    pending[w] = 1'b0;
    ptr        = (w + 1) % N;
  endtask

  // Monitor: pops the scoreboard whenever the DUT acknowledges or writes.
  always @(negedge clk) begin
    ack_t e;
    iss_t s;
    if (reset_i) begin
      chk("reset_outputs_zero", 32'(|{gnt_o, ack_o, err_o, we_o, address_o, data_o, m_data_o}), 32'd0);
    end else begin
      if (|ack_o) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 32'(ack_o), 32'd0);
        else begin
          e = ack_q.pop_front();
          chk("ack_vector", 32'(ack_o), 32'(1) << e.m);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("ack_err", 32'(err_o), 32'(e.err));
          chk("ack_rdata", 32'(m_data_o), 32'(e.rdata));
          chk("ack_gnt", 32'(gnt_o), 32'(1) << e.m);
          chk("ack_addr_held", 32'(address_o), 32'(e.addr));
        end
      end else begin
        chk("err_low_outside_done", 32'(err_o), 32'd0);
      end
      if (we_o) begin
        if (iss_q.size() == 0) chk("unexpected_we", 32'(we_o), 32'd0);
        else begin
          s = iss_q.pop_front();
          chk("we_cycle", 32'(cyc), 32'(s.cyc));
          chk("we_address", 32'(address_o), 32'(s.addr));
          chk("we_data", 32'(data_o), 32'(s.data));
        end
      end
    end
  end

  initial begin
    int w;
    logic [N-1:0] mask;
    for (int m = 0; m < N; m++) pending[m] = 1'b0;
    step();
    step();
    reset_i = 1'b0;

    // Single write by master 0, no halt.
    set_master(0, 1'b1, 16'h0010, 16'h00A5);
    txn(0, '0, 16'h0000, 1'b0, w);
    // Read by master 1 with 4 halt cycles.
    set_master(1, 1'b0, 16'h0020, 16'h0000);
    txn(4, '0, 16'h1234, 1'b0, w);

    // Both masters continuously requesting from reset.
    do_reset();
    rand_master(0);
    rand_master(1);
    for (int k = 0; k < 4; k++) begin
      txn(0, '0, DW'($urandom), 1'b0, w);
      chk("alternating_order", 32'(w), 32'(k % 2));
      if (k < 3) rand_master(w);
    end

    // Timeout with halt held well past the limit.
    txn(T + 4, '0, 16'hBEEF, 1'b0, w);

    // Reset during WAIT, then master 0 must win again.
    rand_master(1);
    txn(2, '0, 16'h5555, 1'b1, w);
    rand_master(1);
    rand_master(0);
    txn(0, '0, 16'h7777, 1'b0, w);
    chk("post_reset_winner", 32'(w), 32'd0);
    req_i[1] = 1'b0; pending[1] = 1'b0;

    // Master 1 raises its request during master 0's WAIT.
    rand_master(0);
    txn(3, 3'b010, 16'h4242, 1'b0, w);
    txn(0, '0, 16'h4343, 1'b0, w);
    chk("late_request_served_next", 32'(w), 32'd1);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      mask = N'($urandom_range(0, (1 << N) - 1));
      for (int m = 0; m < N; m++) if (mask[m] && !pending[m]) rand_master(m);
      if (!(pending[0] || pending[1] || pending[2])) rand_master($urandom_range(0, N - 1));
      mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      txn($urandom_range(0, T + 2), mask, DW'($urandom), 1'b0, w);
    end

    clear_all();
    repeat (6) step();
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("we_queue_drained", 32'(iss_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before error completion; legal range 1..65535.
REQ-003 Parameters address_width and data_width take cpu_reg_package values.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 req_i  input  NUM_MASTERS  per-master request; held high until that master's ack.
REQ-007 m_we_i  input  NUM_MASTERS  per-master write flag.
REQ-008 m_address_i  input  NUM_MASTERS x address_width  per-master address.
REQ-009 m_data_i  input  NUM_MASTERS x data_width  per-master write data.
REQ-010 gnt_o  output  NUM_MASTERS  one-hot; current owner from ISSUE through DONE.
REQ-011 ack_o  output  NUM_MASTERS  one-cycle completion pulse to the owner.
REQ-012 err_o  output  1  high with ack_o when completion was by timeout.
REQ-013 m_data_o  output  data_width  read data, valid while ack_o is high.
REQ-014 we_o  output  1  downstream write strobe.
REQ-015 address_o  output  address_width  downstream address.
REQ-016 data_o  output  data_width  downstream write data.
REQ-017 data_i  input  data_width  downstream read data.
REQ-018 cpu_halt_i  input  1  downstream stall, e.g. a bus_cdc halt.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: if any req_i bit is set, latch the winner and go to ISSUE; otherwise stay in IDLE.
REQ-021 Winner: the first set req_i bit at or after rr_ptr, searching upward with wrap-around.
REQ-022 ISSUE lasts exactly 1 cycle; address_o, data_o and we_o are registered from the winner's inputs.
REQ-023 we_o is high for the single ISSUE cycle only, and only if the winner's m_we_i is high.
REQ-024 address_o and data_o hold their values from ISSUE until the next ISSUE.
REQ-025 WAIT: the timeout counter is cleared on entry and increments every cycle cpu_halt_i is high.
REQ-026 WAIT exit when cpu_halt_i is low: capture data_i into m_data_o and go to DONE with err_o low.
REQ-027 WAIT exit on timeout: when the counter reaches TIMEOUT_CYCLES with cpu_halt_i still high, go to DONE with err_o high and m_data_o = 0.
REQ-028 DONE lasts 1 cycle; ack_o[winner] = 1; rr_ptr = (winner+1) mod NUM_MASTERS; next state IDLE.
REQ-029 Minimum latency: req_i rising in IDLE at cycle 0 gives ack_o at cycle 3 (IDLE to ISSUE to WAIT to DONE, no halt).
REQ-030 Each halt cycle in WAIT adds exactly 1 cycle of latency.
REQ-031 A req_i change during ISSUE, WAIT or DONE does not alter the owner; new requests wait for IDLE.
REQ-032 Throughput: back-to-back requests from one master complete at most once every 4 cycles.
REQ-033 Fairness: with k requesters continuously active, each is served exactly once per k transactions.
REQ-034 m_data_o holds its last value outside DONE; err_o is low outside DONE.
REQ-035 gnt_o is zero in IDLE.

Reset
REQ-036 While reset_i is high: state IDLE, rr_ptr 0, counter 0, and gnt_o, ack_o, err_o, we_o, address_o, data_o, m_data_o all 0.
REQ-037 Reset asserted mid-transaction aborts it with no ack; after release the FSM restarts from IDLE with rr_ptr 0.

Verification
REQ-038 Master 0 writes address 0x10, data 0xA5, no halt -> we_o high exactly 1 cycle with address_o 0x10, data_o 0xA5; ack_o[0] at cycle 3; err_o 0.
REQ-039 Master 1 reads while cpu_halt_i is high 4 cycles, data_i 0x1234 -> ack_o[1] at cycle 7; m_data_o 0x1234.
REQ-040 Both masters request continuously from reset -> grant order 0,1,0,1; acks every 4 cycles.
REQ-041 TIMEOUT_CYCLES=8, cpu_halt_i held high -> ack_o[0] and err_o both high in the DONE cycle after 8 WAIT halt cycles; m_data_o 0.
REQ-042 reset_i pulsed during WAIT -> no ack; all outputs 0; the next request is served from master 0 priority.
REQ-043 Master 1 raises req_i during master 0's WAIT -> master 0 completes first; master 1 is granted in the following IDLE.
